result_bus_arbiter: RTL and testbench
=====================================

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 64: data width per requester; SHALL equal the width of the mux_64_8_1 instance it drives.
REQ-002 Parameter MAX_BURST, default 4, legal 1..15: maximum consecutive grants to one requester while any other requester is pending.
REQ-003 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req  input  8  per-requester request; bit i high means d[i] holds valid data.
REQ-007 d  input  [7:0][WIDTH-1:0]  per-requester data; SHALL be held stable by requester i while req[i]=1 and ack[i]=0.
REQ-008 ack  output  8  one-hot-or-zero; combinational; ack[i]=1 means d[i] is captured at this rising edge.
REQ-009 out_valid  output  1  registered; out_data/out_sel hold a result.
REQ-010 out_data  output  WIDTH  registered; captured mux output.
REQ-011 out_sel  output  3  registered; index of the requester whose data is in out_data.
REQ-012 out_ready  input  1  consumer accepts out_data at the rising edge when out_valid=1.

Function
REQ-013 Data selection SHALL use one mux_64_8_1 instance with s = current winner index and d = d.
REQ-014 load = (|req) && (!out_valid || out_ready); on load, out_data <= mux output, out_sel <= winner, out_valid <= 1, ack[winner] = 1 in the same cycle.
REQ-015 No load and out_valid && out_ready: out_valid <= 0; out_data and out_sel SHALL hold their values.
REQ-016 out_valid && !out_ready: out_data, out_sel and out_valid SHALL hold; ack SHALL be 8'h00.
REQ-017 When load is 0, ack SHALL be 8'h00; ack SHALL never have more than one bit set.
REQ-018 State: last (3 bits, last winner) and burst_cnt (4 bits); both update only on load.
REQ-019 Sticky rule: if req[last]=1 and (burst_cnt < MAX_BURST or no other req bit set), the winner SHALL be last.
REQ-020 Otherwise the winner SHALL be the first set req bit scanning last+1, last+2, ... modulo 8; index 7 wraps to 0.
REQ-021 On load: burst_cnt <= (winner==last) ? min(burst_cnt+1, MAX_BURST) : 1; last <= winner.
REQ-022 Latency: data captured at edge N SHALL appear on out_data/out_sel with out_valid=1 after edge N; the output register accepts a new result every cycle while out_ready=1.
REQ-023 Simultaneous accept and load: the output register SHALL be replaced in the same edge with no bubble cycle.
REQ-024 A requester dropping req[i] before receiving ack SHALL lose no state and cause no ack for that requester.

Reset
REQ-025 While reset=0 at a rising edge: out_valid<=0, out_data<=0, out_sel<=0, last<=7, burst_cnt<=0.
REQ-026 ack SHALL be 8'h00 in every cycle where reset=0, regardless of req.
REQ-027 Reset asserted mid-operation SHALL discard the held result (out_valid=0 next cycle); arbitration after release SHALL start the scan at index 0.

Verification
REQ-028 Reset with req=8'hFF: ack=0, out_valid=0; after release with req=8'h05, ack=8'h01 and the next cycle shows out_sel=0, out_data=d[0].
REQ-029 req=8'hFF held, out_ready=1, MAX_BURST=4: successive out_sel = 0,0,0,0,1,1,1,1,2,... with ack one-hot every cycle.
REQ-030 Backpressure: out_valid=1, out_ready=0 for 5 cycles with req=8'hFF: out_data/out_sel stable and ack=0; first cycle with out_ready=1 loads the next winner with no bubble.
REQ-031 Single requester req=8'h80 for 10 cycles with out_ready=1: out_sel=7 every cycle; burst_cnt saturates at 4; no lockout.
REQ-032 Wrap-around: last=7, burst_cnt=4, req=8'h81: winner=0; then with req=8'h80 only, winner=7.
REQ-033 Reset pulsed while out_valid=1 and out_ready=0: out_valid=0 after the edge; with req=8'h82 after release, first winner=1.

Source files
------------

// File: rtl/result_bus_arbiter_if.sv
// Requester/consumer bundle for result_bus_arbiter: eight requesters on one side,
// a single registered result port toward the consumer on the other.
interface result_bus_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [7:0]            req;
  logic [7:0][WIDTH-1:0] d;
  logic [7:0]            ack;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [2:0]            out_sel;
  logic                  out_ready;

  modport master (
    output req, d, out_ready,
    input  ack, out_valid, out_data, out_sel
  );

  modport slave (
    input  req, d, out_ready,
    output ack, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/result_bus_arbiter.sv
// Eight-way result bus arbiter: round-robin with bounded stickiness, feeding one
// registered output slot that reloads in the same edge it is drained.
module mux_64_8_1 #(
  parameter int WIDTH = 64
) (
  input  logic [2:0]            s,
  input  logic [7:0][WIDTH-1:0] d,
  output logic [WIDTH-1:0]      y
);
  always_comb begin
    y = d[s];
  end
endmodule

module result_bus_arbiter #(
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  result_bus_arbiter_if.slave  bus
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic [2:0]       last_q, last_d;
  logic [3:0]       burst_q, burst_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_sel_q, out_sel_d;

  logic [2:0]       winner_s;
  logic [2:0]       idx_s;
  logic [7:0]       others_s;
  logic             found_s;
  logic             load_s;
  logic [WIDTH-1:0] mux_y_s;

  mux_64_8_1 #(.WIDTH(WIDTH)) u_mux (
    .s (winner_s),
    .d (bus.d),
    .y (mux_y_s)
  );

  // burst_q==0 only right after reset: there is no previous winner to stick to,
  // so the scan starts at last+1 = 0.
  always_comb begin
    winner_s = last_q;
    idx_s    = last_q;
    found_s  = 1'b0;
    others_s = bus.req & ~(8'b0000_0001 << last_q);
    if ((burst_q != 4'd0) && bus.req[last_q] &&
        ((burst_q < MAX_CNT) || (others_s == 8'h00))) begin
      winner_s = last_q;
      found_s  = 1'b1;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        idx_s = last_q + 3'(k);
        if (!found_s && bus.req[idx_s]) begin
          winner_s = idx_s;
          found_s  = 1'b1;
        end else begin
          found_s  = found_s;
        end
      end
    end
  end

  always_comb begin
    load_s = reset && (|bus.req) && (!out_valid_q || bus.out_ready);
    if (load_s) begin
      bus.ack = 8'b0000_0001 << winner_s;
    end else begin
      bus.ack = 8'h00;
    end
  end

  always_comb begin
    last_d      = last_q;
    burst_d     = burst_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y_s;
      out_sel_d   = winner_s;
      last_d      = winner_s;
      if (winner_s == last_q) begin
        burst_d = (burst_q >= MAX_CNT) ? MAX_CNT : (burst_q + 4'd1);
      end else begin
        burst_d = 4'd1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q      <= 3'd7;
      burst_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 3'd0;
    end else begin
      last_q      <= last_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: reference arbitration model plus a result
// scoreboard drained by an independent monitor on every consumer handshake.
module tb_result_bus_arbiter;
  localparam int W  = 64;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;

  result_bus_arbiter_if #(.WIDTH(W)) bus ();

  result_bus_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] data;
  } res_t;

  res_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_last  = 7;
  int         m_cnt   = 0;
  bit         m_valid = 1'b0;
  logic [7:0] prev_req = 8'h00;
  logic [7:0] prev_ack = 8'h00;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference winner: stay with the last winner while its burst allowance lasts
  // (or nobody else wants the bus), otherwise the next requester after it in ring order.
  function automatic int pick(input logic [7:0] r);
    int others = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != m_last && r[i]) others++;
    end
    if (m_cnt != 0 && r[m_last] && (m_cnt < MB || others == 0)) return m_last;
    for (int k = 1; k <= 8; k++) begin
      if (r[(m_last + k) % 8]) return (m_last + k) % 8;
    end
    return 0;
  endfunction

  task automatic step(input logic rst_v, input logic [7:0] r, input logic rdy);
    logic [7:0] exp_ack;
    logic       rdy_v;
    bit         ld;
    int         w;
    @(posedge clk);
    #1;
    rdy_v         = rst_v ? rdy : 1'b0;
    reset         = rst_v;
    bus.req       = r;
    bus.out_ready = rdy_v;
    for (int i = 0; i < 8; i++) begin
      if (!(prev_req[i] && !prev_ack[i])) bus.d[i] = {$urandom, $urandom};
    end
    @(negedge clk);
    check("out_valid", W'(bus.out_valid), W'(m_valid));
    ld      = rst_v && (r != 8'h00) && (!m_valid || rdy_v);
    w       = ld ? pick(r) : 0;
    exp_ack = ld ? (8'h01 << w) : 8'h00;
    check("ack", W'(bus.ack), W'(exp_ack));
    prev_req = r;
    prev_ack = exp_ack;
    if (!rst_v) begin
      m_valid = 1'b0;
      m_last  = 7;
      m_cnt   = 0;
      sb_q.delete();
    end else if (ld) begin
      sb_q.push_back('{sel: 3'(w), data: bus.d[w]});
      m_cnt   = (w == m_last) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 1;
      m_last  = w;
      m_valid = 1'b1;
    end else if (m_valid && rdy_v) begin
      m_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got sel %0d data %0h expected no result", bus.out_sel, bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check("out_sel", W'(bus.out_sel), W'(e.sel));
        check("out_data", bus.out_data, e.data);
      end
    end
  end

  initial begin
    int seq[12];
    seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    reset         = 1'b0;
    bus.req       = 8'h00;
    bus.d         = '0;
    bus.out_ready = 1'b0;

    // Reset with everyone requesting, then first grant scans from 0.
    repeat (3) step(1'b0, 8'hFF, 1'b1);
    step(1'b1, 8'h05, 1'b1);
    check("post_reset_ack", W'(bus.ack), W'(8'h01));
    step(1'b1, 8'h00, 1'b1);

    // Burst limit with all requesters active.
    step(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 8'hFF, 1'b1);
      check("burst_seq", W'(bus.ack), W'(8'h01 << seq[k]));
    end

    // Backpressure: hold, then reload without a bubble.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'hFF, 1'b0);
      check("bp_ack", W'(bus.ack), W'(8'h00));
    end
    step(1'b1, 8'hFF, 1'b1);
    check("bp_release_ack", W'(bus.ack), W'(8'h08));

    // Lone requester 7 keeps the bus.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 8'h80, 1'b1);
      check("single_ack", W'(bus.ack), W'(8'h80));
    end

    // Wrap from 7 to 0, then back to 7.
    step(1'b1, 8'h81, 1'b1);
    check("wrap_ack0", W'(bus.ack), W'(8'h01));
    step(1'b1, 8'h80, 1'b1);
    check("wrap_ack7", W'(bus.ack), W'(8'h80));

    // Reset while a result is stalled.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'h82, 1'b1);
    check("reset_stall_ack", W'(bus.ack), W'(8'h02));

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      step(($urandom_range(0, 99) != 0), r, ($urandom_range(0, 3) != 0));
    end

    repeat (4) step(1'b1, 8'h00, 1'b1);
    check("drain_empty", W'(sb_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
